// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit:
// the fetch FSM encoding, the opcode field geometry and the HALT decode helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    HALTED  = 2'd3
  } fetch_state_t;

  // Opcode occupies the top OPCODE_W bits of the instruction word
  localparam int OPCODE_W = 4;
  localparam logic [OPCODE_W-1:0] HALT_OP_DEFAULT = 4'hF;

  function automatic logic is_halt(input logic [OPCODE_W-1:0] opcode,
                                   input logic [OPCODE_W-1:0] halt_op);
    return (opcode == halt_op);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of control, memory and issue signals around the fetch unit.
// master = the fetch unit itself, slave = datapath/memory side.
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 16
);
  logic               step;
  logic               run;
  logic               pc_load;
  logic [ADDR_W-1:0]  pc_target;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rd_en;
  logic [INSTR_W-1:0] mem_rdata;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               halt;
  logic [ADDR_W-1:0]  pc;

  modport master (
    input  step, run, pc_load, pc_target, mem_rdata,
    output mem_addr, mem_rd_en, instr, instr_valid, halt, pc
  );

  modport slave (
    output step, run, pc_load, pc_target, mem_rdata,
    input  mem_addr, mem_rd_en, instr, instr_valid, halt, pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch FSM: reads sync ROM at pc, issues one word per fetch with a
// single-cycle strobe, honours PC redirects and stops for good on HALT.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                  ADDR_W  = 4,
  parameter int                  INSTR_W = 16,
  parameter logic [OPCODE_W-1:0] HALT_OP = HALT_OP_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master bus
);

  fetch_state_t       state_r;
  logic [ADDR_W-1:0]  pc_r;
  logic [ADDR_W-1:0]  target_q_r;
  logic               load_pend_r;
  logic [INSTR_W-1:0] instr_r;
  logic               instr_valid_r;
  logic               halt_r;
  logic               mem_rd_en_r;
  logic [ADDR_W-1:0]  next_pc_s;
  logic               halt_hit_s;

  // Successor PC: a redirect arriving in CAPTURE or one already pending beats the increment
  always_comb begin
    next_pc_s = pc_r + ADDR_W'(1);
    if (bus.pc_load) begin
      next_pc_s = bus.pc_target;
    end else if (load_pend_r) begin
      next_pc_s = target_q_r;
    end else begin
      next_pc_s = pc_r + ADDR_W'(1);
    end
  end

  assign halt_hit_s = is_halt(bus.mem_rdata[INSTR_W-1 -: OPCODE_W], HALT_OP);

  // Fetch FSM with all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      pc_r          <= '0;
      target_q_r    <= '0;
      load_pend_r   <= 1'b0;
      instr_r       <= '0;
      instr_valid_r <= 1'b0;
      halt_r        <= 1'b0;
      mem_rd_en_r   <= 1'b0;
    end else begin
      instr_valid_r <= 1'b0;
      mem_rd_en_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          // Redirect lands first so a same-cycle step reads the new target
          if (bus.pc_load) begin
            pc_r <= bus.pc_target;
          end
          if ((bus.step || bus.run) && !halt_r) begin
            state_r     <= READ;
            mem_rd_en_r <= 1'b1;
          end
        end
        READ: begin
          state_r <= CAPTURE;
          if (bus.pc_load) begin
            load_pend_r <= 1'b1;
            target_q_r  <= bus.pc_target;
          end
        end
        CAPTURE: begin
          load_pend_r <= 1'b0;
          if (halt_hit_s) begin
            halt_r  <= 1'b1;
            state_r <= HALTED;
          end else begin
            instr_r       <= bus.mem_rdata;
            instr_valid_r <= 1'b1;
            pc_r          <= next_pc_s;
            if (bus.run) begin
              state_r     <= READ;
              mem_rd_en_r <= 1'b1;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        HALTED: begin
          state_r <= HALTED;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr    = pc_r;
  assign bus.mem_rd_en   = mem_rd_en_r;
  assign bus.instr       = instr_r;
  assign bus.instr_valid = instr_valid_r;
  assign bus.halt        = halt_r;
  assign bus.pc          = pc_r;

endmodule
